// File: rtl/fetch_stage_buffered.sv
// Instruction fetch stage with a small prefetch FIFO.
// Holds the fetch PC, issues one request at a time to a variable-latency
// instruction memory, buffers the responses and hands {instr, pc, pc+4} to
// decode with a valid/ready stall handshake. An execute-stage redirect
// flushes the buffer and discards whatever response is still in flight.
// Optional build macro: FETCH_PERF_EN adds stall/flush cycle counters.
`timescale 1ns/1ps

module fetch_stage_buffered #(
    parameter int              XLEN      = 32,
    parameter int              BUF_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] target_e,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_d,
    input  logic            ready_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] S_REQ  = 2'd0;  // free to issue a request
    localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding, keep its response
    localparam logic [1:0] S_DROP = 2'd2;  // one request outstanding, discard its response

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] req_addr;

    logic [31:0]     buf_instr  [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc     [BUF_DEPTH];
    logic [XLEN-1:0] buf_pcplus4[BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic req_fire;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request side: never issue while a redirect is pending this cycle, and only
    // when the slot for the response is already guaranteed in the FIFO.
    assign full           = (count == CNT_W'(BUF_DEPTH));
    assign imem_req_valid = rst && (state == S_REQ) && !full && !redirect_e;
    assign imem_req_addr  = pc_f;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only if no redirect arrived while (or when) it returned.
    assign push    = (state == S_WAIT) && imem_rsp_valid && !redirect_e;
    assign valid_d = (count != '0);
    assign pop     = valid_d && ready_d;

    // Decode sees the registered FIFO head, or a NOP bubble when empty.
    assign instr_d   = valid_d ? buf_instr[rd_ptr]   : NOP_INSTR;
    assign pc_d      = valid_d ? buf_pc[rd_ptr]      : '0;
    assign pcplus4_d = valid_d ? buf_pcplus4[rd_ptr] : '0;

    // Next-state logic for the single-outstanding-request tracker.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (avoids a latch).
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire) state_nxt = redirect_e ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                // A response in the redirect cycle is simply not pushed; nothing is left in flight.
                if (imem_rsp_valid)  state_nxt = S_REQ;
                else if (redirect_e) state_nxt = S_DROP;
            end
            S_DROP: begin
                // The owed response is consumed here even if another redirect arrives with it.
                if (imem_rsp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // State, fetch PC and the address of the outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= S_REQ;
            pc_f     <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (req_fire) req_addr <= pc_f;
            if (redirect_e)    pc_f <= target_e & ~XLEN'(3);
            else if (req_fire) pc_f <= pc_f + XLEN'(4);
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_e) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: storage is not reset; valid_d gates every read so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr]   <= imem_rsp_data;
            buf_pc[wr_ptr]      <= req_addr;
            buf_pcplus4[wr_ptr] <= req_addr + XLEN'(4);
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters for decode back-pressure cycles and redirect cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (valid_d && !ready_d && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_e && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Self-checking bench for fetch_stage_buffered: a variable-latency memory
// responder, a reference model of the fetch PC and a scoreboard queue of the
// entries decode should see, in order.
`timescale 1ns/1ps

module tb_fetch_stage_buffered;

    localparam int          XLEN      = 32;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect_e;
    logic [31:0] target_e;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_stage_buffered #(
        .XLEN     (XLEN),
        .BUF_DEPTH(BUF_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_e    (redirect_e),
        .target_e      (target_e),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .valid_d       (valid_d),
        .ready_d       (ready_d),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pcplus4_d     (pcplus4_d)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } entry_t;

    entry_t      sb_q[$];
    logic [31:0] exp_pc      = RESET_PC;
    logic [31:0] out_addr    = '0;
    bit          out_live    = 1'b0;
    int          hs_count    = 0;
    int          pop_count   = 0;
    int          flush_model = 0;
    int          stall_model = 0;
    int          mem_lat     = 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request handshake at a given address; returns just after that edge.
    task automatic wait_hs(input logic [31:0] addr, input int budget, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (rst && imem_req_valid && imem_req_ready && imem_req_addr == addr) found = 1'b1;
        end
        check(tag, found, 1);
        if (found) tick();
    endtask

    // Wait for a response that will be consumed without a redirect; returns just after that edge.
    task automatic wait_rsp(input int budget, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (rst && imem_rsp_valid && !redirect_e) found = 1'b1;
        end
        check(tag, found, 1);
        if (found) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    // Memory responder: one response per accepted request after mem_lat cycles.
    initial begin
        logic [31:0] a;
        int          lat;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst && imem_req_valid && imem_req_ready) begin
                a   = imem_req_addr;
                lat = mem_lat;
                tick();
                repeat (lat - 1) tick();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(a);
                tick();
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Reference model and scoreboard, evaluated mid-cycle for the coming edge.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                exp_pc      = RESET_PC;
                out_live    = 1'b0;
                hs_count    = 0;
                flush_model = 0;
                stall_model = 0;
            end else begin
                check("valid_d", valid_d, sb_q.size() != 0);
                if (valid_d && !ready_d) stall_model++;
                if (valid_d && ready_d && !redirect_e && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("instr_d",   instr_d,   e.instr);
                    check("pc_d",      pc_d,      e.pc);
                    check("pcplus4_d", pcplus4_d, e.pcplus4);
                    pop_count++;
                end
                if (imem_rsp_valid) begin
                    if (out_live && !redirect_e)
                        sb_q.push_back({mem_word(out_addr), out_addr, out_addr + 32'd4});
                    out_live = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_pc);
                    out_addr = exp_pc;
                    out_live = !redirect_e;
                    exp_pc   = exp_pc + 32'd4;
                    hs_count++;
                end
                if (redirect_e) begin
                    exp_pc   = target_e & ~32'h3;
                    out_live = 1'b0;
                    sb_q.delete();
                    flush_model++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int pops0;

        rst            = 1'b0;
        redirect_e     = 1'b0;
        target_e       = '0;
        imem_req_ready = 1'b1;
        ready_d        = 1'b0;

        // Reset values
        #3;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_valid_d",   valid_d,        0);
        check("rst_instr",     instr_d,        32'h13);
        check("rst_pc",        pc_d,           0);
        check("rst_pcplus4",   pcplus4_d,      0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Decode stalled: FIFO fills with two entries, then requests stop
        repeat (20) tick();
        @(negedge clk);
        check("stall_req_off", imem_req_valid, 0);
        check("stall_valid",   valid_d,        1);
        check("stall_head_pc", pc_d,           RESET_PC);
        check("stall_reqs",    hs_count,       BUF_DEPTH);
        @(posedge clk);
        #1 ready_d = 1'b1;

        // Streaming with a 1-cycle memory: one instruction per two cycles
        pops0 = pop_count;
        repeat (40) tick();
        check("throughput", (pop_count - pops0) >= 19, 1);

        // Memory refuses requests: address holds, PC does not advance
        imem_req_ready = 1'b0;
        repeat (3) tick();
        hs0 = hs_count;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", imem_req_valid, 1);
            check("hold_addr",  imem_req_addr,  exp_pc);
        end
        check("hold_no_fire", hs_count, hs0);
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        repeat (4) tick();
        check("hold_release", (hs_count - hs0) >= 1, 1);

        // Redirect while waiting on the response for 0x8
        do_reset();
        mem_lat = 3;
        wait_hs(32'h8, 30, "wait_req_8");
        redirect_e = 1'b1;
        target_e   = 32'h100;
        tick();
        redirect_e = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                if (valid_d) seen = 1'b1;
            end
            check("redir_wait_seen", seen, 1);
            check("redir_wait_pc",   pc_d, 32'h100);
        end

        // Redirect to an unaligned target from S_REQ; check the redirect latency
        mem_lat = 1;
        wait_rsp(30, "wait_rsp_a");
        redirect_e = 1'b1;
        target_e   = 32'h203;
        @(negedge clk);
        check("redir_req_gate", imem_req_valid, 0);
        @(posedge clk);
        #1 redirect_e = 1'b0;
        @(negedge clk);
        check("redir_lat_req",  imem_req_valid, 1);
        check("redir_lat_addr", imem_req_addr,  32'h200);
        @(negedge clk);
        @(negedge clk);
        check("redir_lat_valid", valid_d, 1);
        check("redir_lat_pc",    pc_d,    32'h200);

        // PC wrap at the top of the address space
        wait_rsp(30, "wait_rsp_b");
        redirect_e = 1'b1;
        target_e   = 32'hFFFF_FFF8;
        tick();
        redirect_e = 1'b0;
        wait_hs(32'h0, 30, "wrap_req_0");
        repeat (6) tick();

        // Random traffic: back-pressure on both sides, varying latency, redirects
        for (int i = 0; i < 400; i++) begin
            ready_d        = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_e     = ($urandom_range(0, 19) == 0);
            target_e       = $urandom;
            mem_lat        = $urandom_range(1, 3);
            tick();
        end
        redirect_e     = 1'b0;
        ready_d        = 1'b1;
        imem_req_ready = 1'b1;
        repeat (12) tick();
`ifdef FETCH_PERF_EN
        check("perf_flush", perf_flush_cnt, flush_model);
        check("perf_stall", perf_stall_cnt, stall_model);
`endif

        // Asynchronous reset while a request is outstanding and the FIFO holds data
        do_reset();
        ready_d = 1'b0;
        mem_lat = 4;
        wait_hs(32'h4, 30, "wait_req_4");
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_valid_d",   valid_d,        0);
        check("arst_req_valid", imem_req_valid, 0);
        check("arst_instr",     instr_d,        32'h13);
        check("arst_pc",        pc_d,           0);
        check("arst_pcplus4",   pcplus4_d,      0);
`ifdef FETCH_PERF_EN
        check("arst_perf_stall", perf_stall_cnt, 0);
        check("arst_perf_flush", perf_flush_cnt, 0);
`endif
        repeat (8) tick();
        rst = 1'b1;
        wait_hs(RESET_PC, 10, "post_reset_req");
        ready_d = 1'b1;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
